// File: rtl/tournament_predictor_p.sv
`default_nettype none
// ============================================================================
// Module   : tournament_predictor_p
// Purpose  : Tournament branch predictor (global PHT, local LHT/PHT, chooser)
//            with registered prediction and a post-reset table sweep.
// Option   : TOURN_GSHARE_EN - global PHT indexed by GHR ^ pc bits.
// Revision : 1.0 - initial release
// ============================================================================
module tournament_predictor_p #(
  parameter int GHR_BITS     = 12,
  parameter int LHT_IDX_BITS = 10,
  parameter int LHIST_BITS   = 10
) (
  input  logic                clock,
  input  logic                reset,
  output logic                ready_o,
  input  logic                pred_valid_i,
  input  logic [31:0]         pred_pc_i,
  output logic                pred_valid_o,
  output logic                pred_taken_o,
  output logic                pred_src_o,
  output logic                pred_global_o,
  output logic                pred_local_o,
  output logic [GHR_BITS-1:0] pred_ghist_o,
  input  logic                upd_valid_i,
  input  logic [31:0]         upd_pc_i,
  input  logic                upd_taken_i,
  input  logic [GHR_BITS-1:0] upd_ghist_i,
  input  logic                upd_global_pred_i,
  input  logic                upd_local_pred_i
);

  localparam int c_MAX_A    = (GHR_BITS > LHT_IDX_BITS) ? GHR_BITS : LHT_IDX_BITS;
  localparam int c_MAX_BITS = (c_MAX_A > LHIST_BITS) ? c_MAX_A : LHIST_BITS;

  typedef enum logic [0:0] {S_INIT = 1'b0, S_READY = 1'b1} state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_MAX_BITS-1:0]   r_init_cnt;
  logic [GHR_BITS-1:0]     r_ghr;

  logic [1:0]            r_gpht [2**GHR_BITS];
  logic [1:0]            r_cho  [2**GHR_BITS];
  logic [LHIST_BITS-1:0] r_lht  [2**LHT_IDX_BITS];
  logic [1:0]            r_lpht [2**LHIST_BITS];

  logic                  r_pred_valid, r_pred_taken, r_pred_src, r_pred_global, r_pred_local;
  logic [GHR_BITS-1:0]   r_pred_ghist;

  logic                    w_init_g, w_init_lht, w_init_lp, w_init_last;
  logic [GHR_BITS-1:0]     w_pidx, w_uidx;
  logic [LHT_IDX_BITS-1:0] w_plht_idx, w_ulht_idx;
  logic [LHIST_BITS-1:0]   w_plh, w_ulh;
  logic                    w_pglob, w_ploc, w_psrc;
  logic                    w_pred_acc, w_upd_acc;
  logic                    w_unused;

  function automatic logic [1:0] f_sat(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    else   return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  // A table takes part in the sweep only while the counter is below its depth.
  generate
    if (GHR_BITS < c_MAX_BITS) begin : g_init_g_part
      assign w_init_g = ~|r_init_cnt[c_MAX_BITS-1:GHR_BITS];
    end else begin : g_init_g_full
      assign w_init_g = 1'b1;
    end
    if (LHT_IDX_BITS < c_MAX_BITS) begin : g_init_lht_part
      assign w_init_lht = ~|r_init_cnt[c_MAX_BITS-1:LHT_IDX_BITS];
    end else begin : g_init_lht_full
      assign w_init_lht = 1'b1;
    end
    if (LHIST_BITS < c_MAX_BITS) begin : g_init_lp_part
      assign w_init_lp = ~|r_init_cnt[c_MAX_BITS-1:LHIST_BITS];
    end else begin : g_init_lp_full
      assign w_init_lp = 1'b1;
    end
  endgenerate

  assign w_init_last = &r_init_cnt;
  assign w_pred_acc  = (r_state == S_READY) && pred_valid_i;
  assign w_upd_acc   = (r_state == S_READY) && upd_valid_i;
  assign w_unused    = &{1'b0, pred_pc_i, upd_pc_i};

`ifdef TOURN_GSHARE_EN
  assign w_pidx = r_ghr ^ pred_pc_i[GHR_BITS+1:2];
  assign w_uidx = upd_ghist_i ^ upd_pc_i[GHR_BITS+1:2];
`else
  assign w_pidx = r_ghr;
  assign w_uidx = upd_ghist_i;
`endif

  assign w_plht_idx = pred_pc_i[LHT_IDX_BITS+1:2];
  assign w_ulht_idx = upd_pc_i[LHT_IDX_BITS+1:2];
  assign w_plh      = r_lht[w_plht_idx];
  assign w_ulh      = r_lht[w_ulht_idx];
  assign w_pglob    = r_gpht[w_pidx][1];
  assign w_ploc     = r_lpht[w_plh][1];
  assign w_psrc     = r_cho[r_ghr][1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && w_init_last) w_state_nxt = S_READY;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_init_cnt <= '0;
      r_ghr      <= '0;
    end else if (r_state == S_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end else if (upd_valid_i) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], upd_taken_i};
    end
  end

  // Tables carry no reset; the INIT sweep establishes their contents.
  always_ff @(posedge clock) begin
    if (r_state == S_INIT) begin
      if (w_init_g) begin
        r_gpht[r_init_cnt[GHR_BITS-1:0]] <= 2'b01;
        r_cho[r_init_cnt[GHR_BITS-1:0]]  <= 2'b10;
      end
      if (w_init_lht) r_lht[r_init_cnt[LHT_IDX_BITS-1:0]] <= '0;
      if (w_init_lp)  r_lpht[r_init_cnt[LHIST_BITS-1:0]]  <= 2'b01;
    end else if (w_upd_acc) begin
      r_gpht[w_uidx]     <= f_sat(r_gpht[w_uidx], upd_taken_i);
      r_lpht[w_ulh]      <= f_sat(r_lpht[w_ulh], upd_taken_i);
      r_lht[w_ulht_idx]  <= {w_ulh[LHIST_BITS-2:0], upd_taken_i};
      if (upd_global_pred_i != upd_local_pred_i)
        r_cho[upd_ghist_i] <= f_sat(r_cho[upd_ghist_i], upd_global_pred_i == upd_taken_i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pred_valid  <= 1'b0;
      r_pred_taken  <= 1'b0;
      r_pred_src    <= 1'b0;
      r_pred_global <= 1'b0;
      r_pred_local  <= 1'b0;
      r_pred_ghist  <= '0;
    end else begin
      r_pred_valid <= w_pred_acc;
      if (w_pred_acc) begin
        r_pred_taken  <= w_psrc ? w_pglob : w_ploc;
        r_pred_src    <= w_psrc;
        r_pred_global <= w_pglob;
        r_pred_local  <= w_ploc;
        r_pred_ghist  <= r_ghr;
      end
    end
  end

  assign ready_o       = (r_state == S_READY);
  assign pred_valid_o  = r_pred_valid;
  assign pred_taken_o  = r_pred_taken;
  assign pred_src_o    = r_pred_src;
  assign pred_global_o = r_pred_global;
  assign pred_local_o  = r_pred_local;
  assign pred_ghist_o  = r_pred_ghist;

endmodule
`default_nettype wire

// File: tb/tb_tournament_predictor_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_tournament_predictor_p
// Purpose  : Directed self-checking bench for tournament_predictor_p
//            (small tables; valid with or without TOURN_GSHARE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tournament_predictor_p;

  localparam int c_GHR = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ready_o;
  logic             pred_valid_i = 1'b0;
  logic [31:0]      pred_pc_i = '0;
  logic             pred_valid_o, pred_taken_o, pred_src_o, pred_global_o, pred_local_o;
  logic [c_GHR-1:0] pred_ghist_o;
  logic             upd_valid_i = 1'b0;
  logic [31:0]      upd_pc_i = '0;
  logic             upd_taken_i = 1'b0;
  logic [c_GHR-1:0] upd_ghist_i = '0;
  logic             upd_global_pred_i = 1'b0;
  logic             upd_local_pred_i = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  tournament_predictor_p #(.GHR_BITS(4), .LHT_IDX_BITS(3), .LHIST_BITS(3)) u_dut (
    .clock(clock), .reset(reset), .ready_o(ready_o),
    .pred_valid_i(pred_valid_i), .pred_pc_i(pred_pc_i),
    .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_src_o(pred_src_o),
    .pred_global_o(pred_global_o), .pred_local_o(pred_local_o), .pred_ghist_o(pred_ghist_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_ghist_i(upd_ghist_i), .upd_global_pred_i(upd_global_pred_i),
    .upd_local_pred_i(upd_local_pred_i)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Release reset and check the 16-cycle sweep with requests being ignored.
  task automatic do_init(input string tag);
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'h100;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk({tag, "_ready_lo"}, ready_o, 1'b0);
      if (i == 16) chk({tag, "_ready_hi"}, ready_o, 1'b1);
      if (i == 8 || i == 16) chk({tag, "_pv_init"}, pred_valid_o, 1'b0);
    end
    pred_valid_i = 1'b0;
    tick();
  endtask

  // Expected fields packed as {valid, taken, src, global, local, ghist}.
  task automatic predict(input string tag, input logic [31:0] pc, input logic [8:0] exp);
    pred_valid_i = 1'b1;
    pred_pc_i    = pc;
    tick();
    pred_valid_i = 1'b0;
    chk(tag, {pred_valid_o, pred_taken_o, pred_src_o, pred_global_o, pred_local_o, pred_ghist_o}, exp);
    tick();
    chk({tag, "_pulse"}, pred_valid_o, 1'b0);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [3:0] gh,
                        input logic gp, input logic lp);
    upd_valid_i       = 1'b1;
    upd_pc_i          = pc;
    upd_taken_i       = t;
    upd_ghist_i       = gh;
    upd_global_pred_i = gp;
    upd_local_pred_i  = lp;
    tick();
    upd_valid_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_pv", pred_valid_o, 1'b0);
    do_init("init0");

    predict("cold", 32'h100, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});

    for (int i = 0; i < 6; i++) update(32'h100, 1'b1, 4'hF, 1'b0, 1'b0);
    predict("trained_t", 32'h100, {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF});

    // Mid-stream reset with a prediction in flight.
    pred_valid_i = 1'b1;
    pred_pc_i    = 32'h100;
    tick();
    pred_valid_i = 1'b0;
    chk("pre_rst_pv", pred_valid_o, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ready", ready_o, 1'b0);
    chk("mid_rst_pv", pred_valid_o, 1'b0);
    do_init("init1");
    predict("post_rst", 32'h100, {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});

    for (int i = 0; i < 2; i++) update(32'h200, 1'b0, 4'h0, 1'b1, 1'b0);
    predict("chooser_local", 32'h200, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0});

    // Same-cycle predict and update: prediction must see the old GHR.
    pred_valid_i      = 1'b1;
    pred_pc_i         = 32'h100;
    upd_valid_i       = 1'b1;
    upd_pc_i          = 32'h100;
    upd_taken_i       = 1'b1;
    upd_ghist_i       = 4'h0;
    upd_global_pred_i = 1'b0;
    upd_local_pred_i  = 1'b0;
    tick();
    upd_valid_i = 1'b0;
    chk("same_cyc_ghist", pred_ghist_o, 4'h0);
    chk("same_cyc_pv", pred_valid_o, 1'b1);
    tick();
    pred_valid_i = 1'b0;
    chk("b2b_pv", pred_valid_o, 1'b1);
    chk("b2b_ghist", pred_ghist_o, 4'h1);
    tick();
    chk("b2b_end_pv", pred_valid_o, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
